// File: rtl/csa_ctrl_pkg.sv
// Shared definitions for the carry-save accumulator controller: FSM encoding
// and the accumulator width derivation.
package csa_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Wide enough to hold MAX_OPS full-scale operands without wrapping.
  function automatic int calc_acc_w(input int w, input int max_ops);
    return w + $clog2(max_ops);
  endfunction

endpackage

// File: rtl/csa_accum_ctrl_if.sv
// Operand-in / result-out handshake bundle for csa_accum_ctrl.
interface csa_accum_ctrl_if
  import csa_ctrl_pkg::*;
#(
  parameter int W       = 4,
  parameter int MAX_OPS = 16
);
  localparam int ACC_W = calc_acc_w(W, MAX_OPS);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/csa_row.sv
// N-bit 3:2 compressor: per-bit full adder, carry vector returned unshifted.
module csa_row #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] c_i,
  output logic [N-1:0] sum_o,
  output logic [N-1:0] cy_o
);
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c_i[i];
    assign cy_o[i]  = (a_i[i] & b_i[i]) | (a_i[i] & c_i[i]) | (b_i[i] & c_i[i]);
  end
endmodule

// File: rtl/csa_accum_ctrl.sv
// Multi-operand accumulator: keeps the running total in carry-save form and
// resolves it to binary after the last beat by re-feeding S/C through the row.
module csa_accum_ctrl
  import csa_ctrl_pkg::*;
#(
  parameter int W       = 4,
  parameter int MAX_OPS = 16,
  localparam int ACC_W  = calc_acc_w(W, MAX_OPS)
) (
  input  logic             clk,
  input  logic             rst,
  csa_accum_ctrl_if.slave  bus,
  output logic [ACC_W-1:0] op_count,
  output logic             busy
);
  localparam logic [ACC_W-1:0] CNT_MAX = ACC_W'(MAX_OPS);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] s_q, s_d, c_q, c_d;
  logic [ACC_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             ov_q, ov_d;
  logic [ACC_W-1:0] osum_q, osum_d;
  logic             oovf_q, oovf_d;

  logic [ACC_W-1:0] row_a, row_b, row_x, row_s, row_c;
  logic             accept;

  // IDLE clears the old total by zeroing the S/C inputs; RESOLVE zeroes the operand.
  assign row_a = (state_q == ST_IDLE) ? '0 : s_q;
  assign row_b = (state_q == ST_IDLE) ? '0 : c_q;
  assign row_x = (state_q == ST_RESOLVE) ? '0 : {{(ACC_W-W){1'b0}}, bus.in_data};

  csa_row #(.N(ACC_W)) u_row (
    .a_i   (row_a),
    .b_i   (row_b),
    .c_i   (row_x),
    .sum_o (row_s),
    .cy_o  (row_c)
  );

  assign bus.in_ready  = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = ov_q;
  assign bus.out_sum   = osum_q;
  assign bus.out_ovf   = oovf_q;
  assign op_count      = cnt_q;
  assign busy          = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    ov_d    = ov_q;
    osum_d  = osum_q;
    oovf_d  = oovf_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          s_d     = row_s;
          c_d     = {row_c[ACC_W-2:0], 1'b0};
          ovf_d   = row_c[ACC_W-1];
          cnt_d   = ACC_W'(1);
          state_d = bus.in_last ? ST_RESOLVE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          s_d   = row_s;
          c_d   = {row_c[ACC_W-2:0], 1'b0};
          ovf_d = ovf_q | row_c[ACC_W-1] | (cnt_q == CNT_MAX);
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if (bus.in_last) state_d = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        if (c_q == '0) begin
          osum_d  = s_q;
          oovf_d  = ovf_q;
          ov_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          s_d   = row_s;
          c_d   = {row_c[ACC_W-2:0], 1'b0};
          ovf_d = ovf_q | row_c[ACC_W-1];
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          ov_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ov_q    <= 1'b0;
      osum_q  <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ov_q    <= ov_d;
      osum_q  <= osum_d;
      oovf_q  <= oovf_d;
    end
  end
endmodule
